// File: rtl/hdb3_plug_vb.sv
// rtl/hdb3_plug_vb.sv - HDB3 front end: classifies NRZ bits into zero/mark/B/V symbols
// Delay line holds N_ZERO symbols so a completed zero run can be rewritten in place.
module hdb3_plug_vb #(
  parameter int N_ZERO = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       data_in,
  output logic [1:0] data_plug_b,
  output logic       out_valid
);

  localparam int CW = $clog2(N_ZERO + 1);
  localparam logic [1:0] SYM_ZERO = 2'b00;
  localparam logic [1:0] SYM_MARK = 2'b01;
  localparam logic [1:0] SYM_B    = 2'b10;
  localparam logic [1:0] SYM_V    = 2'b11;

  logic [1:0]    sr_q [N_ZERO];
  logic [1:0]    sr_d [N_ZERO];
  logic [1:0]    plug_q;
  logic [CW-1:0] zero_cnt_q, zero_cnt_d;
  logic [CW-1:0] fill_cnt_q, fill_cnt_d;
  logic          parity_q, parity_d;
  logic          valid_q, valid_d;
  logic          subst;

  assign subst = !data_in && (zero_cnt_q == CW'(N_ZERO - 1));

  always_comb begin
    sr_d[0]    = data_in ? SYM_MARK : SYM_ZERO;
    for (int i = 1; i < N_ZERO; i++) begin
      sr_d[i] = sr_q[i-1];
    end
    zero_cnt_d = zero_cnt_q;
    parity_d   = parity_q;
    if (subst) begin
      // B and V cancel, so the pulse count is even again after a substitution.
      sr_d[0]          = SYM_V;
      sr_d[N_ZERO-1]   = parity_q ? SYM_ZERO : SYM_B;
      zero_cnt_d       = '0;
      parity_d         = 1'b0;
    end else if (data_in) begin
      zero_cnt_d = '0;
      parity_d   = ~parity_q;
    end else begin
      zero_cnt_d = zero_cnt_q + 1'b1;
    end
    fill_cnt_d = (fill_cnt_q == CW'(N_ZERO)) ? fill_cnt_q : fill_cnt_q + 1'b1;
    valid_d    = (fill_cnt_q == CW'(N_ZERO));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_ZERO; i++) begin
        sr_q[i] <= SYM_ZERO;
      end
      plug_q     <= SYM_ZERO;
      zero_cnt_q <= '0;
      fill_cnt_q <= '0;
      parity_q   <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      for (int i = 0; i < N_ZERO; i++) begin
        sr_q[i] <= sr_d[i];
      end
      plug_q     <= sr_q[N_ZERO-1];
      zero_cnt_q <= zero_cnt_d;
      fill_cnt_q <= fill_cnt_d;
      parity_q   <= parity_d;
      valid_q    <= valid_d;
    end
  end

  assign data_plug_b = plug_q;
  assign out_valid   = valid_q;

endmodule

// File: tb/tb_hdb3_plug_vb.sv
// tb/tb_hdb3_plug_vb.sv - self-checking bench for hdb3_plug_vb
// Model encodes the whole post-reset bit sequence into a symbol list, then delays it.
module tb_hdb3_plug_vb;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       data_in = 1'b0;
  logic [1:0] data_plug_b;
  logic       out_valid;

  hdb3_plug_vb #(.N_ZERO(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .data_in     (data_in),
    .data_plug_b (data_plug_b),
    .out_valid   (out_valid)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [1:0] enc[$];
  int         t = 0;
  int         zc = 0;
  bit         par = 1'b0;
  bit         known = 1'b0;
  logic [1:0] exp_sym = 2'b00;
  logic       exp_valid = 1'b0;

  // Encoding rule: N zeros in a row become V; the run's first zero becomes B when the
  // pulse count since the last V is even.
  task automatic model_edge(input logic r, input logic b);
    if (r) begin
      enc.delete();
      t = 0; zc = 0; par = 1'b0; known = 1'b1;
    end else begin
      t++;
      if (b) begin
        enc.push_back(2'b01); zc = 0; par = ~par;
      end else begin
        enc.push_back(2'b00); zc++;
        if (zc == N) begin
          enc[t-1] = 2'b11;
          if (!par) enc[t-N] = 2'b10;
          zc = 0; par = 1'b0;
        end
      end
    end
    exp_valid = (t > N);
    exp_sym   = (t > N) ? enc[t-N-1] : 2'b00;
  endtask

  task automatic step(input logic r, input logic b);
    @(negedge clk);
    rst = r; data_in = b;
    @(posedge clk);
    #1 model_edge(r, b);
  endtask

  always @(negedge clk) begin
    if (known) begin
      n_cmp++;
      if (data_plug_b !== exp_sym || out_valid !== exp_valid) begin
        n_bad++;
        $display("FAIL stream t=%0d: got sym=%b valid=%b, want sym=%b valid=%b",
                 t, data_plug_b, out_valid, exp_sym, exp_valid);
      end
    end
  end

  task automatic pin(input string name, input int n, input logic [31:0] lit);
    logic [1:0] want;
    for (int i = 0; i < n; i++) begin
      want = lit[2*(n-1-i) +: 2];
      n_cmp++;
      if (enc.size() <= i || enc[i] !== want) begin
        n_bad++;
        $display("FAIL pin %s[%0d]: got %b, want %b", name, i,
                 (enc.size() > i) ? enc[i] : 2'bxx, want);
      end
    end
  endtask

  task automatic run_bits(input int n, input logic [31:0] bits);
    for (int i = n - 1; i >= 0; i--) step(1'b0, bits[i]);
  endtask

  task automatic flush();
    for (int i = 0; i < N + 2; i++) step(1'b0, 1'b1);
  endtask

  initial begin
    // Reset hold of 3 cycles, then continuous marks.
    step(1'b1, 1'b1); step(1'b1, 1'b1); step(1'b1, 1'b1);
    run_bits(12, 32'hFFF);
    pin("ones", 6, 32'b01_01_01_01_01_01);

    step(1'b1, 1'b0);
    run_bits(8, 32'h00);
    flush();
    pin("zeros8", 8, 32'b10_00_00_11_10_00_00_11);

    step(1'b1, 1'b0);
    run_bits(5, 32'b10000);
    flush();
    pin("odd", 5, 32'b01_00_00_00_11);

    step(1'b1, 1'b0);
    run_bits(6, 32'b110000);
    flush();
    pin("even", 6, 32'b01_01_10_00_00_11);

    step(1'b1, 1'b0);
    run_bits(8, 32'b00010001);
    flush();
    pin("runs3", 8, 32'b00_00_00_01_00_00_00_01);

    // Mid-stream reset: pre-reset zeros must not count toward a run.
    step(1'b1, 1'b0);
    run_bits(4, 32'b1000);
    step(1'b1, 1'b0);
    run_bits(1, 32'b0);
    flush();
    pin("midrst", 3, 32'b00_01_01);

    // Zero-heavy pseudo-random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 79) == 0), ($urandom_range(0, 2) == 0));
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hdb3_plug_vb.md
Name: hdb3_plug_vb

Overview:
- Front end of the HDB3 encoder chain.
- Takes the raw NRZ bit stream, one bit per clock, and replaces every run of N_ZERO consecutive zeros with a violation pulse V, preceded by a balancing pulse B when required.
- Emits the 2-bit symbol code consumed directly by the downstream polarity stage: 00 zero, 01 mark, 10 B, 11 V.
- The polarity stage owns alternation and V polarity. This block only classifies and positions symbols.

Parameters:
- N_ZERO, 4: zero-run length triggering substitution. Legal range 3..8; 4 gives standard HDB3.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- data_in  input  1  NRZ data bit, sampled every rising edge of clk.
- data_plug_b  output  2  symbol code: 00 zero, 01 mark, 10 B, 11 V. Registered output.
- out_valid  output  1  high once the delay line holds N_ZERO real input symbols.

Behaviour:
- Reset (rst=1 at a clock edge) clears the following state, mid-stream or not:
  - delay line sr[0..N_ZERO-1] := 00
  - data_plug_b := 00
  - zero_cnt := 0
  - parity := 0 (even)
  - fill_cnt := 0
  - out_valid := 0
- Delay line, normal edge:
  - sr[0] <= (data_in ? 01 : 00)
  - sr[i] <= sr[i-1] for i = 1..N_ZERO-1
  - data_plug_b <= sr[N_ZERO-1]
- Latency: data_in sampled at edge k appears on data_plug_b after edge k+N_ZERO, exactly N_ZERO cycles.
- zero_cnt, width ceil(log2(N_ZERO+1)):
  - data_in=1: zero_cnt := 0.
  - data_in=0: zero_cnt += 1.
- parity: toggles on every mark (01) entering sr[0].
- Substitution edge, defined as data_in=0 with zero_cnt == N_ZERO-1. The run's first zero sits in sr[N_ZERO-2] and its newest zeros in sr[0..N_ZERO-3].
  - sr[0] <= 11 (V), replacing the incoming zero.
  - If parity == 0 (even pulses since last V, including none): sr[N_ZERO-1] <= 10 (B), replacing the shifted first zero of the run.
  - If parity == 1: sr[N_ZERO-1] <= 00 (plain shift).
  - zero_cnt := 0 and parity := 0, in the same edge. B and V cancel, so parity is even after every substitution.
  - data_plug_b still loads the old sr[N_ZERO-1] this edge.
- Substitution decision fields:
  - Only the current zero_cnt and parity decide it.
  - The run under substitution is always fully inside the delay line.
  - No output symbol is ever rewritten after leaving sr.
- Back-to-back runs: 2*N_ZERO zeros produce two independent substitutions. The second always gets B, since parity is even after the first V.
- Start-up: parity starts even, so a first run of N_ZERO zeros after reset encodes as B,0..0,V.
- out_valid:
  - fill_cnt counts edges after reset and saturates at N_ZERO.
  - out_valid is registered, rising on the edge where fill_cnt reaches N_ZERO, so it goes high together with the first real symbol on data_plug_b.
  - Stays high until the next reset.
- No handshake, no backpressure: the downstream stage consumes one symbol per clock unconditionally.
- Pure symbol stream: no X on outputs after the first reset edge.

Test Plan (N_ZERO=4; output sequences start at the first out_valid=1 cycle):
- Reset hold of 3 cycles, then data_in=1 continuous -> data_plug_b=00, out_valid=0 during reset and for 4 cycles after release. Then out_valid=1 and data_plug_b=01 every cycle.
- data_in all zeros from reset release, 8 bits -> data_plug_b = 10,00,00,11,10,00,00,11.
- data_in = 1,0,0,0,0 (odd parity) -> 01,00,00,00,11. No B.
- data_in = 1,1,0,0,0,0 (even parity) -> 01,01,10,00,00,11.
- data_in = 0,0,0,1,0,0,0,1 (runs of 3) -> 00,00,00,01,00,00,00,01. No substitution.
- data_in = 1,0,0,0, then rst=1 for one cycle, then 0 followed by 1s:
  - Only 00 is output until the 4th cycle after reset release, then out_valid=1.
  - Post-reset output begins 00,01,... with no V: zero_cnt and parity were cleared, so the pre-reset zeros do not count.
